id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly upstream of the ALU. Captures decoded operands and control

---
 rtl/id_ex_stage_if.sv | 29 ++
 rtl/id_ex_stage.sv | 72 +++++++
 tb/tb_id_ex_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side, forwarding and ALU-side signals of the ID/EX stage
interface id_ex_stage_if #(parameter int DW = 32, parameter int RW = 5);
  logic in_valid, in_ready, flush;
  logic [DW-1:0] rs_data, rt_data, imm;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic alu_src, reg_dst;
  logic [3:0] ctl_in;
  logic exmem_wr, memwb_wr;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_data, memwb_data;
  logic out_valid, out_ready, illegal_op;
  logic [3:0] alu_ctl, ctl_out;
  logic [DW-1:0] alu_a, alu_b, store_data;
  logic [RW-1:0] dest_idx;
  modport master (
    output in_valid, flush, rs_data, rt_data, imm, rs_idx, rt_idx, rd_idx, alu_op, funct,
           alu_src, reg_dst, ctl_in, exmem_wr, exmem_rd, exmem_data, memwb_wr, memwb_rd,
           memwb_data, out_ready,
    input  in_ready, out_valid, alu_ctl, alu_a, alu_b, store_data, dest_idx, ctl_out, illegal_op
  );
  modport slave (
    input  in_valid, flush, rs_data, rt_data, imm, rs_idx, rt_idx, rd_idx, alu_op, funct,
           alu_src, reg_dst, ctl_in, exmem_wr, exmem_rd, exmem_data, memwb_wr, memwb_rd,
           memwb_data, out_ready,
    output in_ready, out_valid, alu_ctl, alu_a, alu_b, store_data, dest_idx, ctl_out, illegal_op
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode and EX/MEM, MEM/WB forwarding
module id_ex_stage #(parameter int DW = 32, parameter int RW = 5) (
  input logic clk,
  input logic reset,
  id_ex_stage_if.slave bus
);
  logic valid, take, illegal_q, src_q;
  logic [3:0] ctl_q, cout_q, r_ctl, dec_ctl;
  logic [RW-1:0] dest_q, rs_q, rt_q;
  logic [DW-1:0] rs_d, rt_d, imm_q, fwd_a, fwd_b;
  assign take = bus.in_valid && bus.in_ready;
  // R-type funct lookup feeding the ALUOp-level decode; 15 marks an unsupported funct
  always_comb begin
    r_ctl = bus.funct == 6'h20 ? 4'd2 :
            bus.funct == 6'h22 ? 4'd6 :
            bus.funct == 6'h24 ? 4'd0 :
            bus.funct == 6'h25 ? 4'd1 :
            bus.funct == 6'h2A ? 4'd7 :
            bus.funct == 6'h27 ? 4'd12 : 4'd15;
    dec_ctl = bus.alu_op == 2'b00 ? 4'd2 :
              bus.alu_op == 2'b01 ? 4'd6 :
              bus.alu_op == 2'b11 ? 4'd1 : r_ctl;
  end
  // Pipeline register: flush beats capture, capture beats consume, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      ctl_q <= '0;
      illegal_q <= 1'b0;
      dest_q <= '0;
      cout_q <= '0;
      rs_d <= '0;
      rt_d <= '0;
      imm_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      src_q <= 1'b0;
    end else if (bus.flush) begin
      valid <= 1'b0;
    end else if (take) begin
      valid <= 1'b1;
      ctl_q <= dec_ctl;
      illegal_q <= bus.alu_op == 2'b10 && r_ctl == 4'd15;
      dest_q <= bus.reg_dst ? bus.rd_idx : bus.rt_idx;
      cout_q <= bus.ctl_in;
      rs_d <= bus.rs_data;
      rt_d <= bus.rt_data;
      imm_q <= bus.imm;
      rs_q <= bus.rs_idx;
      rt_q <= bus.rt_idx;
      src_q <= bus.alu_src;
    end else if (bus.out_ready) begin
      valid <= 1'b0;
    end
  end
  // Forwarding from the held indices, re-evaluated every cycle so a stalled op sees new results
  always_comb begin
    fwd_a = (bus.exmem_wr && bus.exmem_rd == rs_q && rs_q != '0) ? bus.exmem_data :
            (bus.memwb_wr && bus.memwb_rd == rs_q && rs_q != '0) ? bus.memwb_data : rs_d;
    fwd_b = (bus.exmem_wr && bus.exmem_rd == rt_q && rt_q != '0) ? bus.exmem_data :
            (bus.memwb_wr && bus.memwb_rd == rt_q && rt_q != '0) ? bus.memwb_data : rt_d;
  end
  assign bus.in_ready = !valid || bus.out_ready;
  assign bus.out_valid = valid;
  assign bus.alu_ctl = ctl_q;
  assign bus.illegal_op = illegal_q;
  assign bus.dest_idx = dest_q;
  assign bus.ctl_out = cout_q;
  assign bus.alu_a = fwd_a;
  assign bus.alu_b = src_q ? imm_q : fwd_b;
  assign bus.store_data = fwd_b;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven vectors plus stall, flush and reset sequences for id_ex_stage
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  id_ex_stage_if #(.DW(32), .RW(5)) bus ();
  id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] rsd, rtd, imm;
    logic [4:0] rsi, rti, rdi;
    logic [1:0] op;
    logic [5:0] fn;
    logic src, dst;
    logic [3:0] ctl;
    logic ew;
    logic [4:0] er;
    logic [31:0] ed;
    logic mw;
    logic [4:0] mr;
    logic [31:0] md;
    logic [3:0] e_ctl;
    logic e_ill;
    logic [31:0] e_a, e_b, e_sd;
    logic [4:0] e_dest;
  } vec_t;
  vec_t vecs [15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input vec_t v);
    bus.rs_data = v.rsd; bus.rt_data = v.rtd; bus.imm = v.imm;
    bus.rs_idx = v.rsi; bus.rt_idx = v.rti; bus.rd_idx = v.rdi;
    bus.alu_op = v.op; bus.funct = v.fn; bus.alu_src = v.src; bus.reg_dst = v.dst;
    bus.ctl_in = v.ctl;
    bus.exmem_wr = v.ew; bus.exmem_rd = v.er; bus.exmem_data = v.ed;
    bus.memwb_wr = v.mw; bus.memwb_rd = v.mr; bus.memwb_data = v.md;
  endtask
  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " alu_ctl"}, 32'(bus.alu_ctl), 32'(v.e_ctl));
    chk({tag, " illegal_op"}, 32'(bus.illegal_op), 32'(v.e_ill));
    chk({tag, " alu_a"}, bus.alu_a, v.e_a);
    chk({tag, " alu_b"}, bus.alu_b, v.e_b);
    chk({tag, " store_data"}, bus.store_data, v.e_sd);
    chk({tag, " dest_idx"}, 32'(bus.dest_idx), 32'(v.e_dest));
    chk({tag, " ctl_out"}, 32'(bus.ctl_out), 32'(v.ctl));
  endtask
  initial begin
    //           rsd  rtd  imm          rsi rti rdi op fn    src dst ctl ew er ed     mw mr md     ctl ill a      b            sd     dest
    vecs[0]  = '{5,   7,   0,           1,  2,  3,  2, 6'h20, 0, 1, 8,  0, 0, 0,     0, 0, 0,     2,  0,  5,     7,           7,     3};
    vecs[1]  = '{100, 11,  32'hFFFFFFFC, 4,  9,  3,  0, 6'h00, 1, 0, 13, 0, 0, 0,     0, 0, 0,     2,  0,  100,   32'hFFFFFFFC, 11,   9};
    vecs[2]  = '{20,  3,   0,           1,  2,  4,  2, 6'h22, 0, 1, 8,  0, 0, 0,     0, 0, 0,     6,  0,  20,    3,           3,     4};
    vecs[3]  = '{20,  3,   0,           1,  2,  5,  2, 6'h24, 0, 1, 8,  0, 0, 0,     0, 0, 0,     0,  0,  20,    3,           3,     5};
    vecs[4]  = '{20,  3,   0,           1,  2,  6,  2, 6'h25, 0, 1, 8,  0, 0, 0,     0, 0, 0,     1,  0,  20,    3,           3,     6};
    vecs[5]  = '{20,  3,   0,           1,  2,  7,  2, 6'h2A, 0, 1, 8,  0, 0, 0,     0, 0, 0,     7,  0,  20,    3,           3,     7};
    vecs[6]  = '{20,  3,   0,           1,  2,  8,  2, 6'h27, 0, 1, 8,  0, 0, 0,     0, 0, 0,     12, 0,  20,    3,           3,     8};
    vecs[7]  = '{20,  3,   0,           1,  2,  9,  2, 6'h3F, 0, 1, 8,  0, 0, 0,     0, 0, 0,     15, 1,  20,    3,           3,     9};
    vecs[8]  = '{20,  3,   0,           1,  2,  9,  1, 6'h3F, 0, 0, 0,  0, 0, 0,     0, 0, 0,     6,  0,  20,    3,           3,     2};
    vecs[9]  = '{20,  3,   0,           1,  2,  9,  3, 6'h3F, 0, 0, 2,  0, 0, 0,     0, 0, 0,     1,  0,  20,    3,           3,     2};
    vecs[10] = '{1,   2,   0,           3,  2,  3,  0, 6'h00, 0, 1, 8,  1, 3, 'hAA,  1, 3, 'hBB,  2,  0,  'hAA,  2,           2,     3};
    vecs[11] = '{1,   2,   0,           3,  2,  3,  0, 6'h00, 0, 1, 8,  0, 3, 'hAA,  1, 3, 'hBB,  2,  0,  'hBB,  2,           2,     3};
    vecs[12] = '{1,   2,   0,           0,  0,  3,  0, 6'h00, 0, 1, 8,  1, 0, 'hAA,  1, 0, 'hBB,  2,  0,  1,     2,           2,     3};
    vecs[13] = '{1,   2,   10,          1,  6,  4,  0, 6'h00, 1, 0, 13, 1, 7, 'hDD,  1, 6, 'hCC,  2,  0,  1,     10,          'hCC,  6};
    vecs[14] = '{1,   2,   0,           8,  8,  4,  2, 6'h20, 0, 1, 8,  1, 8, 'h55,  1, 8, 'h66,  2,  0,  'h55, 'h55,        'h55,  4};
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    apply(vecs[0]);
    #3;
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset alu_ctl", 32'(bus.alu_ctl), 0);
    chk("reset illegal_op", 32'(bus.illegal_op), 0);
    chk("reset dest_idx", 32'(bus.dest_idx), 0);
    chk("reset ctl_out", 32'(bus.ctl_out), 0);
    chk("reset alu_a", bus.alu_a, 0);
    chk("reset alu_b", bus.alu_b, 0);
    chk("reset store_data", bus.store_data, 0);
    chk("reset in_ready", 32'(bus.in_ready), 1);
    #4 reset = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      bus.in_valid = 1'b1;
      step();
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end
    bus.in_valid = 1'b0;
    step();
    chk("consume out_valid", 32'(bus.out_valid), 0);
    apply(vecs[0]);
    bus.in_valid = 1'b1;
    step();
    chk("stall load alu_a", bus.alu_a, 5);
    apply(vecs[2]);
    bus.out_ready = 1'b0;
    #1;
    chk("stall in_ready", 32'(bus.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d out_valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("stall%0d alu_ctl", i), 32'(bus.alu_ctl), 2);
      chk($sformatf("stall%0d alu_a", i), bus.alu_a, 5);
      chk($sformatf("stall%0d alu_b", i), bus.alu_b, 7);
      chk($sformatf("stall%0d in_ready", i), 32'(bus.in_ready), 0);
    end
    bus.exmem_wr = 1'b1; bus.exmem_rd = 5'd1; bus.exmem_data = 32'h77;
    #1;
    chk("stall fwd alu_a", bus.alu_a, 32'h77);
    bus.exmem_wr = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(bus.in_ready), 1);
    step();
    chk("release out_valid", 32'(bus.out_valid), 1);
    chk("release alu_a", bus.alu_a, 20);
    chk("release alu_ctl", 32'(bus.alu_ctl), 6);
    bus.in_valid = 1'b0;
    step();
    chk("drain out_valid", 32'(bus.out_valid), 0);
    apply(vecs[0]);
    bus.in_valid = 1'b1;
    step();
    chk("pre-flush out_valid", 32'(bus.out_valid), 1);
    apply(vecs[2]);
    bus.flush = 1'b1;
    step();
    chk("flush out_valid", 32'(bus.out_valid), 0);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    step();
    chk("post-flush out_valid", 32'(bus.out_valid), 0);
    apply(vecs[0]);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("pre-reset out_valid", 32'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    chk("async reset out_valid", 32'(bus.out_valid), 0);
    chk("async reset alu_ctl", 32'(bus.alu_ctl), 0);
    chk("async reset alu_a", bus.alu_a, 0);
    chk("async reset alu_b", bus.alu_b, 0);
    step();
    reset = 1'b0;
    step();
    chk("after reset out_valid", 32'(bus.out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
